// File: rtl/gcd_seq_pkg.sv
// gcd_seq_pkg: shared state encoding and default sizing for the GCD sequencer.
package gcd_seq_pkg;
   typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} gcd_seq_state_t;
   localparam int GCD_SEQ_W       = 4;
   localparam int GCD_SEQ_TIMEOUT = 64;
endpackage

// File: rtl/gcd_seq_timer.sv
// gcd_seq_timer: clear/enable up-counter flagging terminal count TIMEOUT-1.
module gcd_seq_timer
   import gcd_seq_pkg::*;
#(
   parameter int TIMEOUT = GCD_SEQ_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign tc = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/gcd_sequencer.sv
// gcd_sequencer: valid/ready front end driving one iterative GCD core, with
// zero-operand bypass, hang timeout and a consumed-job counter.
module gcd_sequencer
   import gcd_seq_pkg::*;
#(
   parameter int W       = GCD_SEQ_W,
   parameter int TIMEOUT = GCD_SEQ_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   output logic         gcd_rst,
   output logic         gcd_run,
   output logic [W-1:0] gcd_x,
   output logic [W-1:0] gcd_y,
   input  logic [W-1:0] gcd_res,
   input  logic         gcd_done,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_x,
   output logic [W-1:0] out_y,
   output logic [W-1:0] out_gcd,
   output logic         out_timeout,
   output logic [7:0]   job_count
);
   gcd_seq_state_t state, state_nxt;
   logic [W-1:0] x_q, y_q;
   logic tc, accept, bypass;
   assign in_ready = state == IDLE;
   assign accept   = in_valid && in_ready;
   assign bypass   = in_x == '0 || in_y == '0;
   gcd_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != RUN),
      .en    (state == RUN),
      .tc    (tc)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? (bypass ? RESP : CLR) : IDLE;
         CLR:     state_nxt = RUN;
         RUN:     state_nxt = (gcd_done || tc) ? RESP : RUN;
         RESP:    state_nxt = out_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x_q         <= '0;
         y_q         <= '0;
         out_gcd     <= '0;
         out_timeout <= 1'b0;
         job_count   <= '0;
      end else begin
         if (accept) begin
            x_q         <= in_x;
            y_q         <= in_y;
            out_gcd     <= in_x == '0 ? in_y : in_x;
            out_timeout <= 1'b0;
         end
         // done takes priority over a coincident timeout
         if (state == RUN && (gcd_done || tc)) begin
            out_gcd     <= gcd_done ? gcd_res : '0;
            out_timeout <= !gcd_done;
         end
         if (state == RESP && out_ready) job_count <= job_count + 8'd1;
      end
   assign gcd_x     = x_q;
   assign gcd_y     = y_q;
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_valid = state == RESP;
   assign gcd_run   = state == RUN;
   assign gcd_rst   = !rst_n || state == CLR;
endmodule

// File: tb/tb_gcd_sequencer.sv
// tb_gcd_sequencer: directed checks of gcd_sequencer against a behavioral
// subtractive GCD core that can be stalled to force the hang timeout.
module tb_gcd_sequencer;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0] in_x = '0, in_y = '0;
   logic in_ready, gcd_rst, gcd_run, gcd_done, out_valid, out_timeout;
   logic [3:0] gcd_x, gcd_y, gcd_res, out_x, out_y, out_gcd;
   logic [7:0] job_count;
   logic core_en = 1'b1;
   logic [3:0] ca, cb;
   logic cdone;
   int pass = 0, total = 0;
   int jc = 0;
   int cyc, nrst, nrun, first_rst, first_run;

   always #5 clk = ~clk;

   gcd_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .gcd_rst(gcd_rst), .gcd_run(gcd_run),
      .gcd_x(gcd_x), .gcd_y(gcd_y), .gcd_res(gcd_res), .gcd_done(gcd_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_gcd(out_gcd), .out_timeout(out_timeout), .job_count(job_count)
   );

   always @(posedge clk)
      if (gcd_rst) begin
         ca <= gcd_x; cb <= gcd_y; cdone <= 1'b0;
      end else if (gcd_run && !cdone && core_en) begin
         if (ca == cb) cdone <= 1'b1;
         else if (ca > cb) ca <= ca - cb;
         else cb <= cb - ca;
      end
   assign gcd_res  = ca;
   assign gcd_done = cdone && core_en;

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [3:0] x, input logic [3:0] y);
      in_valid = 1'b1; in_x = x; in_y = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid;
      cyc = 0; nrst = 0; nrun = 0; first_rst = -1; first_run = -1;
      while (!out_valid && cyc < 300) begin
         if (gcd_rst) begin nrst++; if (first_rst < 0) first_rst = cyc; end
         if (gcd_run) begin nrun++; if (first_run < 0) first_run = cyc; end
         tick();
         cyc++;
      end
      total++;
      if (!out_valid) $display("FAIL wait_valid: out_valid=%b required 1 within 300 cycles", out_valid);
      else pass++;
   endtask

   task automatic test_reset;
      in_valid = 1'b1; in_x = 4'd3; in_y = 4'd0;
      tick(); tick();
      total++;
      if ({in_ready, gcd_rst, gcd_run, out_valid, out_timeout} !== 5'b11000) $display("FAIL reset_ctrl: got %b required 11000", {in_ready, gcd_rst, gcd_run, out_valid, out_timeout});
      else pass++;
      total++;
      if ({out_x, out_y, out_gcd, gcd_x, job_count} !== 24'd0) $display("FAIL reset_data: got %h required 0", {out_x, out_y, out_gcd, gcd_x, job_count});
      else pass++;
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0 || gcd_rst !== 1'b0) $display("FAIL reset_release: out_valid=%b gcd_rst=%b required 0 0", out_valid, gcd_rst);
      else pass++;
   endtask

   task automatic test_basic;
      send(4'd10, 4'd6);
      wait_valid();
      total++;
      if ({nrst, first_rst, first_run} !== {32'd1, 32'd0, 32'd1}) $display("FAIL basic_seq: nrst=%0d first_rst=%0d first_run=%0d required 1 0 1", nrst, first_rst, first_run);
      else pass++;
      total++;
      if (cyc !== 6) $display("FAIL basic_latency: got %0d required 6", cyc);
      else pass++;
      total++;
      if ({out_gcd, out_x, out_y, out_timeout} !== {4'd2, 4'd10, 4'd6, 1'b0}) $display("FAIL basic_result: gcd=%0d x=%0d y=%0d to=%b required 2 10 6 0", out_gcd, out_x, out_y, out_timeout);
      else pass++;
      tick(); jc++;
      total++;
      if (job_count !== 8'(jc) || out_valid !== 1'b0) $display("FAIL basic_count: job_count=%0d out_valid=%b required %0d 0", job_count, out_valid, jc);
      else pass++;
   endtask

   task automatic test_back_to_back;
      logic [3:0] xs [2] = '{4'd12, 4'd13};
      logic [3:0] ys [2] = '{4'd8, 4'd7};
      logic [3:0] gs [2] = '{4'd4, 4'd1};
      for (int i = 0; i < 2; i++) begin
         total++;
         if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready);
         else pass++;
         send(xs[i], ys[i]);
         wait_valid();
         total++;
         if (nrst !== 1 || first_run !== 1) $display("FAIL b2b_rst%0d: nrst=%0d first_run=%0d required 1 1", i, nrst, first_run);
         else pass++;
         total++;
         if (out_gcd !== gs[i] || out_timeout !== 1'b0) $display("FAIL b2b_result%0d: got %0d to=%b required %0d 0", i, out_gcd, out_timeout, gs[i]);
         else pass++;
         tick(); jc++;
      end
      total++;
      if (job_count !== 8'(jc)) $display("FAIL b2b_count: got %0d required %0d", job_count, jc);
      else pass++;
   endtask

   task automatic test_bypass;
      logic [3:0] xs [2] = '{4'd0, 4'd5};
      logic [3:0] ys [2] = '{4'd9, 4'd0};
      logic [3:0] gs [2] = '{4'd9, 4'd5};
      for (int i = 0; i < 2; i++) begin
         send(xs[i], ys[i]);
         wait_valid();
         total++;
         if (cyc !== 0 || nrun !== 0 || nrst !== 0) $display("FAIL bypass_timing%0d: cyc=%0d nrun=%0d nrst=%0d required 0 0 0", i, cyc, nrun, nrst);
         else pass++;
         total++;
         if (out_gcd !== gs[i] || gcd_run !== 1'b0 || out_timeout !== 1'b0) $display("FAIL bypass_result%0d: got %0d run=%b to=%b required %0d 0 0", i, out_gcd, gcd_run, out_timeout, gs[i]);
         else pass++;
         tick(); jc++;
      end
   endtask

   task automatic test_timeout;
      core_en = 1'b0;
      send(4'd6, 4'd4);
      wait_valid();
      total++;
      if (cyc - first_run !== 64) $display("FAIL timeout_latency: got %0d required 64", cyc - first_run);
      else pass++;
      total++;
      if (out_gcd !== 4'd0 || out_timeout !== 1'b1) $display("FAIL timeout_result: gcd=%0d to=%b required 0 1", out_gcd, out_timeout);
      else pass++;
      tick(); jc++;
      core_en = 1'b1;
      send(4'd10, 4'd6);
      wait_valid();
      total++;
      if (out_gcd !== 4'd2 || out_timeout !== 1'b0) $display("FAIL timeout_next: gcd=%0d to=%b required 2 0", out_gcd, out_timeout);
      else pass++;
      tick(); jc++;
   endtask

   task automatic test_hold;
      out_ready = 1'b0;
      send(4'd10, 4'd6);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({out_valid, in_ready, out_gcd, out_x, out_y, out_timeout} !== {1'b1, 1'b0, 4'd2, 4'd10, 4'd6, 1'b0} || job_count !== 8'(jc))
            $display("FAIL hold%0d: valid=%b ready=%b gcd=%0d x=%0d y=%0d cnt=%0d required 1 0 2 10 6 %0d", i, out_valid, in_ready, out_gcd, out_x, out_y, job_count, jc);
         else pass++;
         tick();
      end
      out_ready = 1'b1;
      tick(); jc++;
      total++;
      if (job_count !== 8'(jc) || out_valid !== 1'b0) $display("FAIL hold_accept: cnt=%0d valid=%b required %0d 0", job_count, out_valid, jc);
      else pass++;
   endtask

   task automatic test_reset_midrun;
      send(4'd10, 4'd6);
      tick();
      total++;
      if (gcd_run !== 1'b1) $display("FAIL midrun_pre: gcd_run=%b required 1", gcd_run);
      else pass++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({gcd_run, gcd_rst, out_valid, in_ready} !== 4'b0101 || job_count !== 8'd0) $display("FAIL midrun_reset: run=%b rst=%b valid=%b ready=%b cnt=%0d required 0 1 0 1 0", gcd_run, gcd_rst, out_valid, in_ready, job_count);
      else pass++;
      tick();
      rst_n = 1'b1;
      tick();
      send(4'd5, 4'd0);
      wait_valid();
      total++;
      if (out_gcd !== 4'd5 || cyc !== 0) $display("FAIL midrun_after: gcd=%0d cyc=%0d required 5 0", out_gcd, cyc);
      else pass++;
      tick();
      total++;
      if (job_count !== 8'd1) $display("FAIL midrun_count: got %0d required 1", job_count);
      else pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bypass();
      test_timeout();
      test_hold();
      test_reset_midrun();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/gcd_sequencer.md
# gcd_sequencer

Initiator-side front end for the team's iterative GCD core. It accepts operand pairs over a valid/ready handshake and drives the core's `rst`/`run`/`xin`/`yin` inputs. It pulses the core's reset between jobs, waits for `done`, captures the result and presents it downstream over a second valid/ready handshake. It sits between a stimulus or CPU-side source and one GCD core instance, and adds zero-operand bypass, a hang timeout and a job counter.

## Interface
Parameters:
- `W`, 4, operand/result width.
- `TIMEOUT`, 64, maximum RUN cycles before a job is abandoned (≥2).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_x`, `in_y`  in  W  operands.
- `gcd_rst`  out  1  active-high reset to the core.
- `gcd_run`  out  1  run to the core.
- `gcd_x`, `gcd_y`  out  W  operands to the core (`xin`/`yin`).
- `gcd_res`  in  W  core result.
- `gcd_done`  in  1  core done.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_x`, `out_y`, `out_gcd`  out  W  echoed operands and result.
- `out_timeout`  out  1  result is from an abandoned job.
- `job_count`  out  8  number of results consumed, wraps 255→0.

## Operation
- States: IDLE, CLR, RUN, RESP.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid&&in_ready`, latch `x`/`y`.
  - If either operand is 0, go to RESP with result = the other operand ((0,0)→0) and `out_timeout`=0. This is the bypass path, and the core is never run.
  - Otherwise go to CLR.
- **CLR**
  - One cycle with `gcd_rst`=1 and `gcd_run`=0.
  - `gcd_done` is ignored.
  - Go to RUN.
- **RUN**
  - `gcd_run`=1 and the timer increments each cycle.
  - On `gcd_done`=1, capture `gcd_res` into `out_gcd` and go to RESP.
  - If the timer reaches `TIMEOUT-1` without `gcd_done`: `out_gcd`=0, `out_timeout`=1, go to RESP.
  - If `gcd_done` and the timeout occur in the same cycle, `gcd_done` wins.
- **RESP**
  - `out_valid`=1; `gcd_run`=0.
  - On `out_ready`: `job_count`+1, go to IDLE.
  - `out_*` are held stable while waiting.
- `gcd_x`/`gcd_y` always drive the latched operands. They are stable from CLR through RESP.
- `gcd_rst` = `~rst_n` OR (state==CLR), so the core is held in reset whenever the sequencer is.
- Only one job is in flight at a time; there is no internal queue.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state IDLE; timer 0; `job_count` 0.
  - `out_valid` 0, `out_x`/`out_y`/`out_gcd` 0, `out_timeout` 0.
  - `gcd_run` 0, `gcd_rst` 1, latched operands 0.
  - `in_ready` reads 1 but no accept occurs while reset is asserted.
- Reset mid-job: the job is dropped silently, no result is emitted, and `job_count` clears.
- Accept at edge N:
  - Bypass: `out_valid` from cycle N+1.
  - Core path: CLR in cycle N+1, RUN from N+2. `gcd_done` sampled high at edge D gives `out_valid` from D+1.
  - Timeout: `out_valid` appears `TIMEOUT` cycles after entering RUN.
- Back-to-back: IDLE lasts at least one cycle between jobs, so the peak rate is one job per 4 cycles plus the core latency.
- `in_ready` is combinational from state. `out_*` are registered.

## Structure
- Package `gcd_seq_pkg`:
  - state enum `gcd_seq_state_t` (IDLE, CLR, RUN, RESP);
  - default-width and default-timeout constants.
- Natural sub-module: `gcd_seq_timer`, a clear/enable up-counter with a terminal-count flag at `TIMEOUT-1`.
- The GCD core is not instantiated inside. The top-level or bench connects the core to the `gcd_*` ports.

## Test plan
- (10,6) through a real core, `out_ready`=1 → `out_gcd`=2, `out_x`=10, `out_y`=6, `gcd_rst` high exactly 1 cycle before `gcd_run`, `job_count`=1.
- (12,8) then (13,7) back-to-back → results 4 then 1, `gcd_rst` pulsed before each job, `job_count`=2.
- (0,9) and (5,0) → results 9 and 5 one cycle after accept, `gcd_run` never asserted.
- Stub core that never asserts done, input (6,4) → `out_valid` exactly 64 cycles after RUN entry with `out_gcd`=0 and `out_timeout`=1. The next job (10,6) returns 2 with `out_timeout`=0.
- (10,6) with `out_ready` held low 5 cycles after `out_valid` → outputs stable, `in_ready`=0, `job_count` increments only on the accepting edge.
- Assert `rst_n` low mid-RUN → immediately `gcd_run`=0, `gcd_rst`=1, `out_valid`=0, `job_count`=0; after release IDLE accepts a new pair.
